// File: rtl/vr_pkg.sv
// Shared types and constants for the valid/ready FIFO.
// Also provides the saturating-increment helper used by the statistics counters.
package vr_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef logic [DEFAULT_DATA_W-1:0] data_t;

    localparam int               STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] r;
        if (v == STAT_MAX) begin
            r = v;
        end else begin
            r = v + STAT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/vr_fifo_mem.sv
// DEPTH x DATA_W storage array for vr_fifo.
// It has one synchronous write port and one asynchronous read port, and the array is not reset.
module vr_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/vr_fifo.sv
// Valid/ready FIFO with first-word fall-through. Status signals are derived from registers only.
// Optional build macro VR_FIFO_STATS_EN adds the stall_cnt and full_cnt statistics ports.
module vr_fifo
    import vr_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [$clog2(DEPTH):0]   count
`ifdef VR_FIFO_STATS_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [15:0]              full_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_s, pop_s;
    logic [DATA_W-1:0] rdata_s;

    assign m_valid = (count_q != {CNT_W{1'b0}});
    assign s_ready = (count_q != CNT_W'(DEPTH));
    assign push_s  = s_valid && s_ready;
    assign pop_s   = m_valid && m_ready;
    assign count   = count_q;
    // The array is not reset, so the output is forced to zero while the FIFO is empty.
    assign m_data  = m_valid ? rdata_s : {DATA_W{1'b0}};

    // Next-state for the pointers and the occupancy count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    vr_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_q),
        .wdata (s_data),
        .raddr (rd_ptr_q),
        .rdata (rdata_s)
    );

`ifdef VR_FIFO_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q;
    logic [STAT_W-1:0] full_cnt_q;

    // Saturating back-pressure counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= {STAT_W{1'b0}};
            full_cnt_q  <= {STAT_W{1'b0}};
        end else begin
            if (m_valid && !m_ready) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (s_valid && !s_ready) begin
                full_cnt_q <= sat_inc(full_cnt_q);
            end else begin
                full_cnt_q <= full_cnt_q;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign full_cnt  = full_cnt_q;
`endif

endmodule

// File: tb/tb_vr_fifo.sv
// Self-checking bench for vr_fifo: directed scenarios plus randomized traffic against a queue model.
// Statistics checks are included when VR_FIFO_STATS_EN is defined.
module tb_vr_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [2:0]        count;
`ifdef VR_FIFO_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       full_cnt;
`endif

    vr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
`ifdef VR_FIFO_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .full_cnt  (full_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] q[$];
    logic [7:0] outq[$];
    logic [7:0] sentq[$];
    bit         last_push;
    bit         last_pop;
    int         stall_m;
    int         full_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] head;
        head = (q.size() != 0) ? q[0] : 8'h00;
        check("count",   32'(count),   32'(q.size()));
        check("m_valid", 32'(m_valid), 32'(q.size() != 0));
        check("s_ready", 32'(s_ready), 32'(q.size() != DEPTH));
        check("m_data",  32'(m_data),  32'(head));
`ifdef VR_FIFO_STATS_EN
        check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
        check("full_cnt",  32'(full_cnt),  32'(full_m));
`endif
    endtask

    // One clock cycle: predict the handshakes from the current inputs, advance the model, then check.
    task automatic step();
        bit pu;
        bit po;
        pu = s_valid && (q.size() != DEPTH);
        po = (q.size() != 0) && m_ready;
        if ((q.size() != 0) && !m_ready && stall_m < 65535) stall_m++;
        if (s_valid && (q.size() == DEPTH) && full_m < 65535) full_m++;
        @(posedge clk);
        if (po) outq.push_back(q.pop_front());
        if (pu) q.push_back(s_data);
        last_push = pu;
        last_pop  = po;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = 8'h00;
        q.delete();
        stall_m = 0;
        full_m  = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int k;
        int sgap;
        int rgap;
        int cyc;

        // Reset, then idle
        do_reset();
        step();
        step();
        check("idle_count", 32'(count), 32'd0);
        check("idle_s_ready", 32'(s_ready), 32'd1);

        // Reset while three words are stored
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h30 + i);
            step();
        end
        s_valid = 1'b0;
        check("pre_reset_count", 32'(count), 32'd3);
        #2;
        reset = 1'b0;
        q.delete();
        stall_m = 0;
        full_m  = 0;
        #1;
        check("async_rst_count",   32'(count),   32'd0);
        check("async_rst_m_valid", 32'(m_valid), 32'd0);
        check("async_rst_m_data",  32'(m_data),  32'd0);
        check("async_rst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        step();
        check("first_after_reset", 32'(m_data), 32'h0000_00AA);
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();

        // Fill to full while blocked, then drain, including the full-cycle simultaneous push/pop
        outq.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h11 * (i + 1));
            step();
            if (i == 3) begin
                check("full_count",   32'(count),   32'd4);
                check("full_s_ready", 32'(s_ready), 32'd0);
            end
        end
        check("held_55_not_taken", 32'(count), 32'd4);
        m_ready = 1'b1;
        step();
        check("full_pop_count", 32'(count), 32'd3);
        step();
        check("push_pop_count", 32'(count), 32'd3);
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("drain_len", 32'(outq.size()), 32'd5);
        for (int i = 0; i < 5 && i < outq.size(); i++) begin
            check("drain_order", 32'(outq[i]), 32'(8'h11 * (i + 1)));
        end

        // Continuous streaming 0..19
        outq.delete();
        k       = 0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        s_data  = 8'h00;
        cyc     = 0;
        while (k < 20 && cyc < 100) begin
            step();
            if (cyc == 0) check("stream_first_valid", 32'(m_valid), 32'd1);
            if (cyc > 0) check("stream_count_1", 32'(count), 32'd1);
            if (last_push) k++;
            s_data = 8'(k);
            cyc++;
        end
        s_valid = 1'b0;
        step();
        step();
        check("stream_len", 32'(outq.size()), 32'd20);
        for (int i = 0; i < 20 && i < outq.size(); i++) begin
            check("stream_data", 32'(outq[i]), 32'(i));
        end

        // Random delays on both sides, 100 words
        void'($urandom(17));
        outq.delete();
        sentq.delete();
        k       = 0;
        sgap    = 0;
        rgap    = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        cyc     = 0;
        while (outq.size() < 100 && cyc < 3000) begin
            if (!s_valid && sgap == 0 && k < 100) begin
                s_valid = 1'b1;
                s_data  = 8'($urandom_range(0, 255));
            end
            m_ready = (rgap == 0);
            step();
            if (last_push) begin
                sentq.push_back(s_data);
                k++;
                s_valid = 1'b0;
                sgap    = $urandom_range(0, 5);
            end else if (!s_valid && sgap > 0) begin
                sgap--;
            end
            if (last_pop) rgap = $urandom_range(0, 5);
            else if (rgap > 0) rgap--;
            cyc++;
        end
        s_valid = 1'b0;
        check("rand_out_len",  32'(outq.size()),  32'd100);
        check("rand_sent_len", 32'(sentq.size()), 32'd100);
        for (int i = 0; i < outq.size() && i < sentq.size(); i++) begin
            check("rand_order", 32'(outq[i]), 32'(sentq[i]));
        end

`ifdef VR_FIFO_STATS_EN
        // Statistics counters
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'h5A;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("stall_cnt_7", 32'(stall_cnt), 32'd7);
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 3; i++) step();
        check("full_cnt_3", 32'(full_cnt), 32'd3);
        s_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
